// File: rtl/key_filter_pkg.sv
// Shared definitions for the push-button conditioner: channel count,
// 50 MHz timing defaults and the per-channel FSM state encoding.
package key_pkg;

  localparam int unsigned NUM_KEYS = 4;

  // 20 ms debounce and 0.5 s long-press at 50 MHz
  localparam logic [24:0] CNT_MAX_DEF  = 25'd999999;
  localparam logic [24:0] HOLD_MAX_DEF = 25'd24999999;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

endpackage

// File: rtl/key_filter_ch.sv
// One key channel: 2-flop synchroniser, debounce FSM with stability counter,
// and long-press timer. All outputs are registered.
module key_filter_ch
  import key_pkg::*;
#(
  parameter logic [24:0] CNT_MAX  = CNT_MAX_DEF,
  parameter logic [24:0] HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic clk50m,
  input  logic rst,
  input  logic key_in,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_hold
);

  logic        sync1, sync2;
  key_state_t  state, state_nxt;
  logic [24:0] cnt, cnt_nxt;
  logic [24:0] hold_cnt, hold_cnt_nxt;
  logic        hold_done, hold_done_nxt;
  logic        state_o_nxt, press_nxt, release_nxt, hold_nxt;

  // Synchroniser resets to the released level so reset never looks like a press
  always_ff @(posedge clk50m or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk50m or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      hold_cnt    <= '0;
      hold_done   <= 1'b0;
      key_state   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_hold    <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      hold_cnt    <= hold_cnt_nxt;
      hold_done   <= hold_done_nxt;
      key_state   <= state_o_nxt;
      key_press   <= press_nxt;
      key_release <= release_nxt;
      key_hold    <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!sync2) state_nxt = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (sync2)               state_nxt = IDLE;
        else if (cnt == CNT_MAX) state_nxt = PRESSED;
      end
      PRESSED: begin
        if (sync2) state_nxt = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (!sync2)              state_nxt = PRESSED;
        else if (cnt == CNT_MAX) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter and pulse updates; hold_cnt only advances while in PRESSED,
  // including the cycle that leaves it, and is frozen across release glitches.
  always_comb begin
    cnt_nxt       = cnt;
    hold_cnt_nxt  = hold_cnt;
    hold_done_nxt = hold_done;
    state_o_nxt   = key_state;
    press_nxt     = 1'b0;
    release_nxt   = 1'b0;
    hold_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (!sync2) cnt_nxt = '0;
      end
      PRESS_WAIT: begin
        if (!sync2) begin
          if (cnt == CNT_MAX) begin
            press_nxt     = 1'b1;
            state_o_nxt   = 1'b1;
            hold_cnt_nxt  = '0;
            hold_done_nxt = 1'b0;
          end else begin
            cnt_nxt = cnt + 25'd1;
          end
        end
      end
      PRESSED: begin
        if (hold_cnt != HOLD_MAX) hold_cnt_nxt = hold_cnt + 25'd1;
        if (!hold_done && (hold_cnt == HOLD_MAX - 25'd1)) begin
          hold_nxt      = 1'b1;
          hold_done_nxt = 1'b1;
        end
        if (sync2) cnt_nxt = '0;
      end
      RELEASE_WAIT: begin
        if (sync2) begin
          if (cnt == CNT_MAX) begin
            release_nxt   = 1'b1;
            state_o_nxt   = 1'b0;
            hold_done_nxt = 1'b0;
          end else begin
            cnt_nxt = cnt + 25'd1;
          end
        end
      end
      default: begin
        cnt_nxt = '0;
      end
    endcase
  end

endmodule

// File: rtl/key_filter.sv
// Four-channel push-button conditioner: independent debounced levels plus
// press, release and long-press pulses per key.
module key_filter
  import key_pkg::*;
#(
  parameter logic [24:0] CNT_MAX  = CNT_MAX_DEF,
  parameter logic [24:0] HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic                clk50m,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_hold
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_filter_ch #(
      .CNT_MAX  (CNT_MAX),
      .HOLD_MAX (HOLD_MAX)
    ) u_ch (
      .clk50m      (clk50m),
      .rst         (rst),
      .key_in      (key_in[i]),
      .key_state   (key_state[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i]),
      .key_hold    (key_hold[i])
    );
  end

endmodule

// File: tb/tb_key_filter.sv
// Scoreboard bench for key_filter with CNT_MAX=3, HOLD_MAX=10.
module tb_key_filter;

  logic       clk50m = 1'b0;
  logic       rst    = 1'b0;
  logic [3:0] key_in = 4'b1111;
  logic [3:0] key_state, key_press, key_release, key_hold;

  key_filter #(
    .CNT_MAX  (25'd3),
    .HOLD_MAX (25'd10)
  ) dut (
    .clk50m      (clk50m),
    .rst         (rst),
    .key_in      (key_in),
    .key_state   (key_state),
    .key_press   (key_press),
    .key_release (key_release),
    .key_hold    (key_hold)
  );

  always #10 clk50m = ~clk50m;

  int cyc = 0;
  always @(posedge clk50m) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] p, r, h, s;
  } ev_t;

  ev_t q[$];
  int  errors = 0;
  int  checks = 0;
  int  evn    = 0;

  function automatic void push(int c, logic [3:0] p, logic [3:0] r, logic [3:0] h, logic [3:0] s);
    ev_t e;
    e.cyc = c; e.p = p; e.r = r; e.h = h; e.s = s;
    q.push_back(e);
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk50m);
    #1;
  endtask

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle carrying a pulse must match the oldest expected event
  always @(negedge clk50m) begin
    if (rst && ((key_press | key_release | key_hold) != 4'b0000)) begin
      ev_t e;
      checks++;
      evn++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event#%0d: cyc=%0d press=%b release=%b hold=%b state=%b, expected none",
                 evn, cyc, key_press, key_release, key_hold, key_state);
      end else begin
        e = q.pop_front();
        if (cyc != e.cyc || key_press !== e.p || key_release !== e.r ||
            key_hold !== e.h || key_state !== e.s) begin
          errors++;
          $display("FAIL event#%0d: cyc=%0d press=%b release=%b hold=%b state=%b, expected cyc=%0d press=%b release=%b hold=%b state=%b",
                   evn, cyc, key_press, key_release, key_hold, key_state,
                   e.cyc, e.p, e.r, e.h, e.s);
        end
      end
    end
  end

  initial begin
    int d, r;
    #1;
    chk("reset_outputs", {key_state, key_press, key_release, key_hold}, 16'h0000);
    tick(2);
    rst = 1'b1;

    // Clean press on key 0, held long enough for one hold pulse
    tick(5);
    d = cyc; key_in = 4'b1110;
    push(d + 7,  4'b0001, 4'b0000, 4'b0000, 4'b0001);
    push(d + 17, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
    tick(20);
    r = cyc; key_in = 4'b1111;
    push(r + 7,  4'b0000, 4'b0001, 4'b0000, 4'b0000);
    tick(15);

    // Bounce on key 1: 3 low, 2 high, then stable low; released before hold
    key_in = 4'b1101; tick(3);
    key_in = 4'b1111; tick(2);
    d = cyc; key_in = 4'b1101;
    push(d + 7,  4'b0010, 4'b0000, 4'b0000, 4'b0010);
    tick(9);
    r = cyc; key_in = 4'b1111;
    push(r + 7,  4'b0000, 4'b0010, 4'b0000, 4'b0000);
    tick(15);

    // Long press on key 2
    d = cyc; key_in = 4'b1011;
    push(d + 7,  4'b0100, 4'b0000, 4'b0000, 4'b0100);
    push(d + 17, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    tick(30);
    r = cyc; key_in = 4'b1111;
    push(r + 7,  4'b0000, 4'b0100, 4'b0000, 4'b0000);
    tick(15);

    // Release glitch on key 3: hold delayed by the two frozen cycles
    d = cyc; key_in = 4'b0111;
    push(d + 7,  4'b1000, 4'b0000, 4'b0000, 4'b1000);
    push(d + 19, 4'b0000, 4'b0000, 4'b1000, 4'b1000);
    tick(9);
    key_in = 4'b1111; tick(2);
    key_in = 4'b0111; tick(3);
    chk("glitch_state", {12'h000, key_state}, 16'h0008);
    tick(11);
    r = cyc; key_in = 4'b1111;
    push(r + 7,  4'b0000, 4'b1000, 4'b0000, 4'b0000);
    tick(15);

    // All keys at once
    d = cyc; key_in = 4'b0000;
    push(d + 7,  4'b1111, 4'b0000, 4'b0000, 4'b1111);
    push(d + 17, 4'b0000, 4'b0000, 4'b1111, 4'b1111);
    tick(20);
    r = cyc; key_in = 4'b1111;
    push(r + 7,  4'b0000, 4'b1111, 4'b0000, 4'b0000);
    tick(15);

    // Reset during PRESS_WAIT, then during PRESSED
    key_in = 4'b0000;
    tick(4);
    rst = 1'b0; #1;
    chk("rst_presswait", {key_state, key_press, key_release, key_hold}, 16'h0000);
    tick(2);
    rst = 1'b1;
    d = cyc;
    push(d + 7,  4'b1111, 4'b0000, 4'b0000, 4'b1111);
    tick(9);
    chk("pressed_before_rst", {12'h000, key_state}, 16'h000f);
    rst = 1'b0; #1;
    chk("rst_pressed", {key_state, key_press, key_release, key_hold}, 16'h0000);
    tick(2);
    rst = 1'b1;
    d = cyc;
    push(d + 7,  4'b1111, 4'b0000, 4'b0000, 4'b1111);
    push(d + 17, 4'b0000, 4'b0000, 4'b1111, 4'b1111);
    tick(20);
    r = cyc; key_in = 4'b1111;
    push(r + 7,  4'b0000, 4'b1111, 4'b0000, 4'b0000);

    for (int i = 0; i < 60 && q.size() != 0; i++) tick(1);
    tick(10);
    chk("final_state", {12'h000, key_state}, 16'h0000);
    while (q.size() != 0) begin
      ev_t e;
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_event: expected cyc=%0d press=%b release=%b hold=%b",
               e.cyc, e.p, e.r, e.h);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
